// File: rtl/spi_pkg.sv
// Shared definitions for the SPI peripheral: register offsets, STATUS bit positions and the state enum.
// spi_controller reuses the same package.
package spi_pkg;

  localparam logic [31:0] OFF_STATUS  = 32'h0;
  localparam logic [31:0] OFF_CONTROL = 32'h4;
  localparam logic [31:0] OFF_DATA    = 32'h8;
  localparam logic [31:0] BLOCK_BYTES = 32'hC;

  localparam int BIT_RX_VALID  = 0;
  localparam int BIT_TX_EMPTY  = 1;
  localparam int BIT_OVERRUN   = 2;
  localparam int BIT_BUSY      = 3;
  localparam int BIT_CS_ACTIVE = 4;

  localparam int CTL_ENABLE  = 0;
  localparam int CTL_CLR_OVR = 1;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } spi_state_e;

  function automatic logic [31:0] pack_status(input logic cs_active, input logic busy,
                                              input logic overrun, input logic tx_empty,
                                              input logic rx_valid);
    logic [31:0] s;
    s = '0;
    s[BIT_CS_ACTIVE] = cs_active;
    s[BIT_BUSY]      = busy;
    s[BIT_OVERRUN]   = overrun;
    s[BIT_TX_EMPTY]  = tx_empty;
    s[BIT_RX_VALID]  = rx_valid;
    return s;
  endfunction

endpackage

// File: rtl/spi_peripheral_if.sv
// Memory-mapped register bus between a bus master and the SPI peripheral.
interface spi_peripheral_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wmask;
  logic        wen;
  logic        ren;
  logic [31:0] rdata;
  logic        ready;
  logic        active;

  modport master (output addr, wdata, wmask, wen, ren, input rdata, ready, active);
  modport slave  (input addr, wdata, wmask, wen, ren, output rdata, ready, active);
endinterface

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous input; RST_VAL is the pin's idle level.
module sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/spi_peripheral.sv
// SPI mode-0 peripheral (8-bit, MSB first) with a 3-word register block on a simple memory bus.
// SPI pins are oversampled by clk through 2-FF synchronizers.
module spi_peripheral
  import spi_pkg::*;
#(
  parameter logic [31:0] ADDR = 32'hd100
) (
  input  logic             clk,
  input  logic             rst_n,
  spi_peripheral_if.slave  bus,
  input  logic             sclk,
  input  logic             cs_n,
  input  logic             mosi,
  output logic             miso,
  output logic             miso_oe
);

  logic sclk_s, cs_n_s, mosi_s;

  sync2 #(.RST_VAL(1'b0)) u_sync_sclk (.clk(clk), .rst_n(rst_n), .d_i(sclk), .q_o(sclk_s));
  sync2 #(.RST_VAL(1'b1)) u_sync_cs_n (.clk(clk), .rst_n(rst_n), .d_i(cs_n), .q_o(cs_n_s));
  sync2 #(.RST_VAL(1'b0)) u_sync_mosi (.clk(clk), .rst_n(rst_n), .d_i(mosi), .q_o(mosi_s));

  spi_state_e  state_q;
  logic        sclk_prev_q;
  logic        cs_n_prev_q;
  logic [1:0]  settle_q;
  logic        enable_q;
  logic [7:0]  txbuf_q;
  logic [7:0]  rxbuf_q;
  logic [7:0]  shift_in_q;
  logic [7:0]  shift_out_q;
  logic [2:0]  bit_cnt_q;
  logic        rx_valid_q;
  logic        tx_empty_q;
  logic        overrun_q;

  logic [31:0] offset;
  logic        hit;
  logic        data_wr, data_rd, ctrl_wr;
  logic        sclk_rise, sclk_fall, cs_fall;
  logic        byte_done, load_shift;
  logic [7:0]  tx_next;
  logic [31:0] rdata_c;

  assign offset  = bus.addr - ADDR;
  assign hit     = offset < BLOCK_BYTES;
  assign data_wr = bus.wen & (offset == OFF_DATA) & bus.wmask[0];
  assign ctrl_wr = bus.wen & (offset == OFF_CONTROL) & bus.wmask[0];
  assign data_rd = bus.ren & (offset == OFF_DATA);

  // The synchronizers come out of reset at the idle level; a cs_n already low at release would
  // look like a falling edge, so edges only count once the pipeline reflects the real pin.
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cs_fall   = cs_n_prev_q & ~cs_n_s & (settle_q == 2'd3);

  assign byte_done  = (state_q == ST_ACTIVE) & ~cs_n_s & enable_q & sclk_rise & (bit_cnt_q == 3'd7);
  assign load_shift = ((state_q == ST_IDLE) & cs_fall & enable_q) | byte_done;
  assign tx_next    = tx_empty_q ? 8'h00 : txbuf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      sclk_prev_q <= 1'b0;
      cs_n_prev_q <= 1'b1;
      settle_q    <= 2'd0;
      enable_q    <= 1'b0;
      txbuf_q     <= 8'h00;
      rxbuf_q     <= 8'h00;
      shift_in_q  <= 8'h00;
      shift_out_q <= 8'h00;
      bit_cnt_q   <= 3'd0;
      rx_valid_q  <= 1'b0;
      tx_empty_q  <= 1'b1;
      overrun_q   <= 1'b0;
    end else begin
      sclk_prev_q <= sclk_s;
      cs_n_prev_q <= cs_n_s;
      if (settle_q != 2'd3) settle_q <= settle_q + 2'd1;

      if (ctrl_wr) enable_q <= bus.wdata[CTL_ENABLE];
      if (data_wr) txbuf_q  <= bus.wdata[7:0];

      // A write landing with a load still loads the old txbuf but keeps the new byte pending.
      if (data_wr)         tx_empty_q <= 1'b0;
      else if (load_shift) tx_empty_q <= 1'b1;

      if (byte_done) begin
        rxbuf_q    <= {shift_in_q[6:0], mosi_s};
        rx_valid_q <= 1'b1;
      end else if (data_rd) begin
        rx_valid_q <= 1'b0;
      end

      if (byte_done & rx_valid_q & ~data_rd)       overrun_q <= 1'b1;
      else if (ctrl_wr & bus.wdata[CTL_CLR_OVR])   overrun_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (cs_fall & enable_q) begin
            state_q     <= ST_ACTIVE;
            bit_cnt_q   <= 3'd0;
            shift_out_q <= tx_next;
          end
        end
        ST_ACTIVE: begin
          if (cs_n_s | ~enable_q) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= 3'd0;
          end else if (sclk_rise) begin
            shift_in_q <= {shift_in_q[6:0], mosi_s};
            bit_cnt_q  <= bit_cnt_q + 3'd1;
            if (byte_done) shift_out_q <= tx_next;
          end else if (sclk_fall && bit_cnt_q != 3'd0) begin
            // The falling edge right after a byte boundary must keep the freshly loaded MSB.
            shift_out_q <= {shift_out_q[6:0], 1'b0};
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // NOTE: every path assigns rdata_c via the leading default, so no latch is inferred.
  always_comb begin
    rdata_c = '0;
    if (hit) begin
      case (offset)
        OFF_STATUS:  rdata_c = pack_status(state_q == ST_ACTIVE, bit_cnt_q != 3'd0,
                                           overrun_q, tx_empty_q, rx_valid_q);
        OFF_CONTROL: rdata_c = {31'b0, enable_q};
        OFF_DATA:    rdata_c = {24'b0, rxbuf_q};
        default:     rdata_c = '0;
      endcase
    end
  end

  assign bus.rdata  = rdata_c;
  assign bus.ready  = 1'b1;
  assign bus.active = hit;

  assign miso    = (state_q == ST_ACTIVE) & shift_out_q[7];
  assign miso_oe = (state_q == ST_ACTIVE);

  logic unused_bits;
  assign unused_bits = &{1'b0, bus.wdata[31:8], bus.wmask[3:1]};

endmodule

// File: tb/tb_spi_peripheral.sv
// Directed bench for spi_peripheral: a vector table of full SPI bytes plus hand sequences for
// latency, coincident read, overrun, partial byte, reset and disable corner cases.
module tb_spi_peripheral;
  import spi_pkg::*;

  localparam logic [31:0] ADDR   = 32'hd100;
  localparam logic [31:0] A_STAT = ADDR + 32'h0;
  localparam logic [31:0] A_CTRL = ADDR + 32'h4;
  localparam logic [31:0] A_DATA = ADDR + 32'h8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sclk = 1'b0;
  logic cs_n = 1'b1;
  logic mosi = 1'b0;
  logic miso, miso_oe;

  spi_peripheral_if bus ();

  spi_peripheral #(.ADDR(ADDR)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .sclk   (sclk),
    .cs_n   (cs_n),
    .mosi   (mosi),
    .miso   (miso),
    .miso_oe(miso_oe)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_mis = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    @(negedge clk);
    bus.addr = a; bus.wdata = d; bus.wmask = m; bus.wen = 1'b1;
    @(negedge clk);
    bus.wen = 1'b0; bus.wmask = 4'h0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.addr = a; bus.ren = 1'b1;
    #1 d = bus.rdata;
    @(negedge clk);
    bus.ren = 1'b0;
  endtask

  task automatic peek(input logic [31:0] a, output logic [31:0] d);
    bus.addr = a;
    #1 d = bus.rdata;
  endtask

  // hook 1: check rx_valid latency on the last bit; hook 2: DATA read coinciding with completion.
  task automatic spi_bits(input logic [7:0] tx, input int nbits, input int hook,
                          output logic [7:0] got, output logic oe_seen);
    logic [31:0] r;
    got = 8'h00;
    oe_seen = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      mosi = tx[7-i];
      repeat (4) @(negedge clk);
      got[7-i] = miso;
      if (miso_oe) oe_seen = 1'b1;
      sclk = 1'b1;
      if (i == 7 && hook != 0) begin
        repeat (2) @(negedge clk);
        if (hook == 1) begin
          peek(A_STAT, r);
          check("rx_valid 2 clk after edge", {31'b0, r[BIT_RX_VALID]}, 32'd0);
        end else begin
          bus.addr = A_DATA; bus.ren = 1'b1;
        end
        @(negedge clk);
        if (hook == 1) begin
          peek(A_STAT, r);
          check("rx_valid 3 clk after edge", {31'b0, r[BIT_RX_VALID]}, 32'd1);
        end else begin
          bus.ren = 1'b0;
          peek(A_STAT, r);
          check("coincident read rx_valid/overrun", r & 32'h5, 32'h1);
        end
        @(negedge clk);
      end else begin
        repeat (4) @(negedge clk);
      end
      sclk = 1'b0;
    end
  endtask

  task automatic cs_begin();
    @(negedge clk);
    cs_n = 1'b0;
  endtask

  task automatic cs_end();
    repeat (4) @(negedge clk);
    cs_n = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  typedef struct {
    logic       do_wr;
    logic [7:0] txb;
    logic [7:0] ctrl_byte;
    logic [7:0] exp_miso;
    logic [4:0] exp_status;
  } vec_t;

  vec_t vecs[4];

  initial begin
    logic [31:0] r;
    logic [7:0]  got;
    logic        oe;

    vecs[0] = '{1'b1, 8'hA5, 8'h3C, 8'hA5, 5'b00011};
    vecs[1] = '{1'b0, 8'h00, 8'hFF, 8'h00, 5'b00011};
    vecs[2] = '{1'b1, 8'h96, 8'h5A, 8'h96, 5'b00011};
    vecs[3] = '{1'b1, 8'h01, 8'h80, 8'h01, 5'b00011};

    bus.addr = '0; bus.wdata = '0; bus.wmask = '0; bus.wen = 1'b0; bus.ren = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    peek(A_STAT, r);  check("reset status", r, 32'h2);
    peek(A_CTRL, r);  check("reset control", r, 32'h0);
    peek(A_DATA, r);  check("reset data", r, 32'h0);
    check("reset miso", {31'b0, miso}, 32'd0);
    check("reset miso_oe", {31'b0, miso_oe}, 32'd0);
    check("ready", {31'b0, bus.ready}, 32'd1);
    check("active in block", {31'b0, bus.active}, 32'd1);
    peek(ADDR + 32'hC, r);
    check("read outside block", r, 32'h0);
    check("active outside block", {31'b0, bus.active}, 32'd0);

    bus_write(A_CTRL, 32'h1, 4'hF);
    bus_read(A_CTRL, r);
    check("control enable", r, 32'h1);

    for (int v = 0; v < 4; v++) begin
      if (vecs[v].do_wr) bus_write(A_DATA, {24'h0, vecs[v].txb}, 4'h1);
      cs_begin();
      spi_bits(vecs[v].ctrl_byte, 8, 0, got, oe);
      cs_end();
      check($sformatf("vec%0d miso bits", v), {24'h0, got}, {24'h0, vecs[v].exp_miso});
      check($sformatf("vec%0d miso_oe", v), {31'b0, oe}, 32'd1);
      peek(A_STAT, r);
      check($sformatf("vec%0d status", v), r, {27'b0, vecs[v].exp_status});
      bus_read(A_DATA, r);
      check($sformatf("vec%0d rxbuf", v), r, {24'h0, vecs[v].ctrl_byte});
      peek(A_STAT, r);
      check($sformatf("vec%0d status after read", v), r, 32'h2);
    end

    // rx_valid latency after the 8th sclk rising edge
    cs_begin();
    spi_bits(8'hC3, 8, 1, got, oe);
    cs_end();
    bus_read(A_DATA, r);
    check("latency byte", r, 32'hC3);

    // DATA read in the same cycle as byte completion
    cs_begin();
    spi_bits(8'h11, 8, 0, got, oe);
    spi_bits(8'h77, 8, 2, got, oe);
    cs_end();
    peek(A_STAT, r);
    check("coincident status", r, 32'h3);
    bus_read(A_DATA, r);
    check("coincident rxbuf", r, 32'h77);

    // back-to-back bytes without reading DATA
    cs_begin();
    spi_bits(8'h11, 8, 0, got, oe);
    spi_bits(8'h22, 8, 0, got, oe);
    cs_end();
    peek(A_STAT, r);
    check("overrun status", r, 32'h7);
    bus_write(A_CTRL, 32'h2, 4'hF);
    peek(A_STAT, r);
    check("overrun cleared", r, 32'h3);
    peek(A_CTRL, r);
    check("control after clear", r, 32'h0);
    bus_read(A_DATA, r);
    check("overrun rxbuf", r, 32'h22);
    bus_write(A_CTRL, 32'h1, 4'hF);

    // partial byte aborted by cs_n
    cs_begin();
    spi_bits(8'hF0, 4, 0, got, oe);
    peek(A_STAT, r);
    check("partial mid status", r, 32'h1A);
    cs_end();
    peek(A_STAT, r);
    check("partial aborted status", r, 32'h2);
    cs_begin();
    spi_bits(8'h5A, 8, 0, got, oe);
    cs_end();
    bus_read(A_DATA, r);
    check("after partial rxbuf", r, 32'h5A);

    // reset mid-byte
    bus_write(A_DATA, 32'hE7, 4'h1);
    cs_begin();
    spi_bits(8'h81, 3, 0, got, oe);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid reset miso", {31'b0, miso}, 32'd0);
    check("mid reset miso_oe", {31'b0, miso_oe}, 32'd0);
    peek(A_STAT, r);  check("mid reset status", r, 32'h2);
    peek(A_CTRL, r);  check("mid reset control", r, 32'h0);
    peek(A_DATA, r);  check("mid reset data", r, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    bus_write(A_CTRL, 32'h1, 4'hF);
    spi_bits(8'h99, 8, 0, got, oe);
    check("no fresh cs edge miso_oe", {31'b0, oe}, 32'd0);
    cs_end();
    peek(A_STAT, r);
    check("no fresh cs edge status", r, 32'h2);

    // disabled block ignores sclk
    bus_write(A_CTRL, 32'h0, 4'hF);
    cs_begin();
    spi_bits(8'h42, 8, 0, got, oe);
    cs_end();
    check("disabled miso_oe", {31'b0, oe}, 32'd0);
    peek(A_STAT, r);
    check("disabled status", r, 32'h2);
    bus_write(A_CTRL, 32'h1, 4'hF);
    cs_begin();
    spi_bits(8'h3C, 8, 0, got, oe);
    cs_end();
    bus_read(A_DATA, r);
    check("re-enabled rxbuf", r, 32'h3C);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/spi_peripheral.md
SPI_PERIPHERAL -- requirements
Module: spi_peripheral

Interface
REQ-001 Parameter ADDR, default 32'hd100, base address of the 3-word register block.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset, as the ports below.
REQ-003 clk  in  1  system clock; all state on rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 addr  in  32, wdata  in  32, wmask  in  4, wen  in  1, ren  in  1  bus request.
REQ-006 rdata  out  32  combinational read data; ready  out  1  tied 1; active  out  1  addr hits the block.
REQ-007 sclk  in  1, cs_n  in  1 (active-low), mosi  in  1  external SPI controller pins, asynchronous to clk.
REQ-008 miso  out  1  serial data to controller; miso_oe  out  1  tristate enable for the top level.

Function
REQ-009 Map: ADDR+0 STATUS (RO), ADDR+4 CONTROL (RW), ADDR+8 DATA (W: txbuf=wdata[7:0] if wmask[0]; R: {24'b0, rxbuf}); other addresses read 0.
REQ-010 STATUS = {27'b0, cs_active, busy, overrun, tx_empty, rx_valid}; busy = bit counter nonzero.
REQ-011 CONTROL[0] enable; CONTROL[1] write-1 clears overrun, self-clears, reads 0; other bits read 0.
REQ-012 sclk, cs_n, mosi SHALL each pass a 2-FF synchronizer; edges are detected on synchronized sclk; requires f_clk >= 4*f_sclk.
REQ-013 Mode 0, MSB first, 8-bit: sample mosi on sclk rising edge, update miso on sclk falling edge.
REQ-014 States IDLE, ACTIVE; IDLE->ACTIVE on synchronized cs_n falling while enable=1; ACTIVE->IDLE on cs_n high or enable=0.
REQ-015 On IDLE->ACTIVE: shift_out loads txbuf if tx_empty=0, else 8'h00; tx_empty<=1; bit counter<=0.
REQ-016 On 8th rising edge: rxbuf<=assembled byte, rx_valid<=1, counter<=0, shift_out reloads per REQ-015 for back-to-back bytes.
REQ-017 If rx_valid=1 at byte completion and no DATA read that cycle, overrun<=1 and rxbuf is overwritten.
REQ-018 DATA read (ren & addr==ADDR+8) clears rx_valid; if a byte completes the same cycle, rx_valid stays 1 and overrun does not set.
REQ-019 DATA write sets tx_empty<=0; a write coinciding with a shift_out load loads the old txbuf and leaves tx_empty=0.
REQ-020 cs_n rising mid-byte SHALL discard the partial byte, reset the counter, and leave rxbuf and rx_valid unchanged.
REQ-021 miso = shift_out[7] when ACTIVE, else 0; miso_oe = 1 only when ACTIVE.
REQ-022 rx_valid asserts 3 clk cycles after the 8th sclk rising edge at the pin.

Reset
REQ-023 rst_n low SHALL asynchronously force IDLE, control=0, txbuf=0, rxbuf=0, shift registers=0, counter=0, rx_valid=0, tx_empty=1, overrun=0, synchronizers=idle level (sclk 0, cs_n 1), miso=0, miso_oe=0.
REQ-024 Reset mid-transfer SHALL abort without updating rxbuf; after release, a new transfer requires a fresh cs_n falling edge.

Structure
REQ-025 Register offsets, STATUS bit indices and the state enum SHALL reside in shared package spi_pkg, reused by spi_controller.
REQ-026 A single sub-module sync2 (2-FF synchronizer, async active-low reset, parameterized reset value) SHALL be instantiated per input pin.

Verification
REQ-027 Write DATA=8'hA5, enable, controller sends 8'h3C at clk/8 -> miso shifts 10100101, rxbuf=8'h3C, rx_valid=1, tx_empty=1.
REQ-028 Two back-to-back bytes 8'h11, 8'h22 without reading DATA -> overrun=1, rxbuf=8'h22; CONTROL write 2 -> overrun=0.
REQ-029 No txbuf write, controller sends 8'hFF -> miso bits all 0, rxbuf=8'hFF.
REQ-030 cs_n deasserted after 4 bits -> rx_valid unchanged, busy=0; next full byte 8'h5A received correctly.
REQ-031 DATA read in the same cycle as byte completion -> rx_valid=1, overrun=0.
REQ-032 rst_n pulsed low mid-byte -> all REQ-023 values immediately; enable=0 -> sclk ignored, miso_oe=0.
